inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction-fetch sequencer for the SCPU0 core. Owns the program counter and drives the address of the 64×32 combinational instruction ROM. Captures each fetched word into an IF/ID register with a valid flag. Applies decode-stage stalls, branch/jump redirects and a halt/resume control, and replaces the CPU's bare PC register between the ROM and the decoder.

## Interface
Parameters:
- ADDR_W, 6: ROM word-address width; the PC is ADDR_W bits.
- DATA_W, 32: instruction width.
- RESET_PC, 6'h01: PC loaded on reset. Word 0 is reserved as an empty slot, so execution starts at 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_W  ROM address; always equals the internal pc.
- rom_inst  in  DATA_W  combinational ROM data for rom_addr.
- id_stall  in  1  decode cannot accept; hold the IF/ID register and pc.
- redirect  in  1  taken branch or jump resolved in decode.
- redirect_pc  in  ADDR_W  target word address, valid with redirect.
- halt  in  1  request to stop fetching.
- resume  in  1  leave HALT.
- if_inst  out  DATA_W  IF/ID instruction.
- if_pc  out  ADDR_W  address of if_inst.
- if_valid  out  1  if_inst is a real (non-bubble) instruction.
- halted  out  1  state == HALT.
- fetch_cnt  out  16  count of accepted fetches; saturates at 16'hFFFF.
- dbg_step_mode  in  1  present only with IFETCH_STEP_EN.
- dbg_step  in  1  present only with IFETCH_STEP_EN; one-cycle step pulse.

## Operation
- States: RUN, HALT, STEP (STEP exists only with IFETCH_STEP_EN). rst forces RUN.
- Reset values: pc = RESET_PC, if_inst = 0, if_pc = 0, if_valid = 0, fetch_cnt = 0, halted = 0.
- Per-edge priority, in all states:
  1. rst
  2. redirect
  3. id_stall
  4. advance permission
- Redirect:
  - pc <= redirect_pc.
  - if_valid <= 0, flushing the wrong-path word fetched this cycle.
  - fetch_cnt unchanged.
  - State transitions are still evaluated in the same cycle.
- Stall (no redirect): pc, if_inst, if_pc, if_valid and fetch_cnt all hold.
- Accepted fetch (RUN, no redirect, no stall):
  - if_inst <= rom_inst, if_pc <= pc, if_valid <= 1.
  - pc <= pc + 1, modulo 2^ADDR_W, so 6'h3F wraps to 6'h00.
  - fetch_cnt increments unless it is already saturated.
- RUN -> HALT when halt = 1.
  - The fetch in that cycle is not accepted.
  - If id_stall = 0, if_valid <= 0; otherwise the IF/ID register is held.
- In HALT:
  - No fetch is accepted; pc holds unless redirected.
  - if_valid clears on the first cycle with id_stall = 0.
- HALT -> RUN when resume = 1 and halt = 0. The first fetch is accepted on the following cycle.
- halt and resume both asserted: halt wins, and the block stays in or enters HALT.

## Timing
- Fetch latency is one cycle: the word at rom_addr in cycle N appears on if_inst after edge N.
- After rst deasserts, the first accepted edge loads ROM[RESET_PC] into if_inst.
- Redirect penalty is one bubble: if_valid = 0 for one cycle, then ROM[redirect_pc] follows.
- Redirect together with id_stall: the redirect still loads pc and clears if_valid. The stalled instruction is discarded because decode redirected on its behalf.
- rst asserted mid-stall, mid-halt or mid-step returns all outputs to their reset values on that edge.
- halted is registered and asserted the cycle after HALT is entered.

## Configuration
IFETCH_STEP_EN selects single-step debug.

Defined:
- dbg_step_mode and dbg_step ports exist.
- RUN -> STEP when dbg_step_mode = 1.
- In STEP, a fetch is accepted only on a cycle with dbg_step = 1 (plus no stall and no redirect).
- On non-step cycles the IF/ID register holds, and if_valid clears once id_stall = 0.
- STEP -> RUN when dbg_step_mode = 0.
- halt from STEP goes to HALT. resume from HALT returns to STEP if dbg_step_mode = 1, else to RUN.

Undefined: the ports are absent, the STEP state is absent, and behaviour is identical to dbg_step_mode = 0.

## Test plan
- Reset and free run (ROM loaded with the SCPU0 test program): after rst, cycle 1 gives if_pc = 01, if_inst = 28033046, if_valid = 1; cycle 2 gives if_pc = 02, if_inst = 00101464; fetch_cnt = 2.
- Stall: assert id_stall for 3 cycles while if_pc = 03. if_inst stays 38000866, rom_addr stays 04, fetch_cnt stays 3; the next cycle gives if_pc = 04.
- Redirect: redirect = 1 with redirect_pc = 0A. Next cycle if_valid = 0; the following cycle gives if_pc = 0A, if_inst = 04100841. Repeat with redirect and id_stall both asserted: same result.
- Wrap and saturation: redirect to 3F and run, giving if_pc 3F then 00, with no error. Preload fetch_cnt near FFFF via a long run; it holds at FFFF.
- Halt and resume:
  - Pulse halt at pc = 05: if_valid drops, halted = 1, rom_addr is frozen for 10 cycles.
  - Assert halt and resume together: the block stays halted.
  - resume alone: the next fetch gives if_pc = 05.
- With IFETCH_STEP_EN: set dbg_step_mode = 1 and pulse dbg_step 3 times, 4 cycles apart. Exactly 3 fetches are accepted (if_pc 01, 02, 03), with if_valid = 0 between pulses.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl_if
// Brief    : Fetch-stage bus between the PC sequencer, the instruction ROM
//            and the decoder. Debug-step signals exist only with IFETCH_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;
    logic              id_stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              resume;
    logic [DATA_W-1:0] if_inst;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;
    logic              halted;
    logic [15:0]       fetch_cnt;
`ifdef IFETCH_STEP_EN
    logic              dbg_step_mode;
    logic              dbg_step;
`endif

    modport master (
        output rom_addr,
        input  rom_inst,
        input  id_stall,
        input  redirect,
        input  redirect_pc,
        input  halt,
        input  resume,
        output if_inst,
        output if_pc,
        output if_valid,
        output halted,
        output fetch_cnt
`ifdef IFETCH_STEP_EN
        ,
        input  dbg_step_mode,
        input  dbg_step
`endif
    );

    modport slave (
        input  rom_addr,
        output rom_inst,
        output id_stall,
        output redirect,
        output redirect_pc,
        output halt,
        output resume,
        input  if_inst,
        input  if_pc,
        input  if_valid,
        input  halted,
        input  fetch_cnt
`ifdef IFETCH_STEP_EN
        ,
        output dbg_step_mode,
        output dbg_step
`endif
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl
// Brief    : SCPU0 instruction-fetch sequencer: PC, IF/ID register, stall,
//            redirect and halt/resume. IFETCH_STEP_EN adds single-step debug.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 'd1
) (
    input  logic clk,
    input  logic rst,
    inst_fetch_ctrl_if.master bus
);

`ifdef IFETCH_STEP_EN
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1
    } state_t;
`endif

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_if_inst;
    logic [ADDR_W-1:0] r_if_pc;
    logic              r_if_valid;
    logic [15:0]       r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_accept means the current state permits a fetch; stall/redirect veto it later.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.halt) begin
                    w_state_nxt = ST_HALT;
`ifdef IFETCH_STEP_EN
                end else if (bus.dbg_step_mode) begin
                    w_state_nxt = ST_STEP;
`endif
                end else begin
                    w_accept = 1'b1;
                end
            end
            ST_HALT: begin
                if (!bus.halt && bus.resume) begin
`ifdef IFETCH_STEP_EN
                    w_state_nxt = bus.dbg_step_mode ? ST_STEP : ST_RUN;
`else
                    w_state_nxt = ST_RUN;
`endif
                end
            end
`ifdef IFETCH_STEP_EN
            ST_STEP: begin
                if (bus.halt) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    if (!bus.dbg_step_mode) begin
                        w_state_nxt = ST_RUN;
                    end
                    w_accept = bus.dbg_step;
                end
            end
`endif
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Redirect overrides stall: the stalled word is discarded on decode's behalf.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_if_inst   <= '0;
            r_if_pc     <= '0;
            r_if_valid  <= 1'b0;
            r_fetch_cnt <= '0;
        end else if (bus.redirect) begin
            r_pc       <= bus.redirect_pc;
            r_if_valid <= 1'b0;
        end else if (!bus.id_stall) begin
            if (w_accept) begin
                r_if_inst  <= bus.rom_inst;
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
                r_pc       <= r_pc + 1'b1;
                if (r_fetch_cnt != c_cnt_max) begin
                    r_fetch_cnt <= r_fetch_cnt + 16'd1;
                end
            end else begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign bus.rom_addr  = r_pc;
    assign bus.if_inst   = r_if_inst;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_valid  = r_if_valid;
    assign bus.halted    = (r_state == ST_HALT);
    assign bus.fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Brief    : Directed and random checks of inst_fetch_ctrl against a
//            cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    inst_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(6'h01)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] rom [64];
    assign bus.rom_inst = rom[bus.rom_addr];

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b1;

    // reference model state
    logic [5:0]  m_pc;
    logic [5:0]  m_if_pc;
    logic [31:0] m_if_inst;
    bit          m_valid;
    bit          m_halt;
    bit          m_step;
    int          m_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit sm;
        bit sp;
        bit take;
`ifdef IFETCH_STEP_EN
        sm = bus.dbg_step_mode;
        sp = bus.dbg_step;
`else
        sm = 1'b0;
        sp = 1'b0;
`endif
        if (rst) begin
            m_pc = 6'h01; m_if_pc = '0; m_if_inst = '0; m_valid = 0;
            m_halt = 0; m_step = 0; m_cnt = 0;
        end else begin
            take = !bus.redirect && !bus.id_stall && !bus.halt &&
                   ((!m_halt && !m_step && !sm) || (!m_halt && m_step && sp));
            if (bus.redirect) begin
                m_pc = bus.redirect_pc;
                m_valid = 0;
            end else if (take) begin
                m_if_inst = rom[m_pc];
                m_if_pc   = m_pc;
                m_valid   = 1;
                m_pc      = m_pc + 6'd1;
                if (m_cnt < 65535) m_cnt++;
            end else if (!bus.id_stall) begin
                m_valid = 0;
            end
            if (bus.halt) m_halt = 1;
            else if (m_halt) begin
                if (bus.resume) begin
                    m_halt = 0;
                    m_step = sm;
                end
            end else m_step = sm;
        end
    endtask

    task automatic compare_all();
        check_val("rom_addr", bus.rom_addr, m_pc);
        check_val("if_valid", bus.if_valid, m_valid);
        check_val("if_pc", bus.if_pc, m_if_pc);
        check_val("if_inst", bus.if_inst, m_if_inst);
        check_val("halted", bus.halted, m_halt);
        check_val("fetch_cnt", bus.fetch_cnt, m_cnt[15:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        if (chk_en) compare_all();
    endtask

    task automatic clear_inputs();
        bus.id_stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
        bus.halt = 0; bus.resume = 0;
`ifdef IFETCH_STEP_EN
        bus.dbg_step_mode = 0; bus.dbg_step = 0;
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[1]  = 32'h28033046;
        rom[2]  = 32'h00101464;
        rom[3]  = 32'h38000866;
        rom[10] = 32'h04100841;

        clear_inputs();
        rst = 1;
        @(negedge clk);
        tick(); tick();
        check_val("rst_valid", bus.if_valid, 0);
        check_val("rst_addr", bus.rom_addr, 6'h01);
        check_val("rst_cnt", bus.fetch_cnt, 0);

        // free run from reset
        rst = 0;
        tick();
        check_val("run1_pc", bus.if_pc, 6'h01);
        check_val("run1_inst", bus.if_inst, 32'h28033046);
        check_val("run1_valid", bus.if_valid, 1);
        tick();
        check_val("run2_pc", bus.if_pc, 6'h02);
        check_val("run2_inst", bus.if_inst, 32'h00101464);
        check_val("run2_cnt", bus.fetch_cnt, 2);
        tick();
        check_val("run3_pc", bus.if_pc, 6'h03);

        // stall three cycles
        bus.id_stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("stall_inst", bus.if_inst, 32'h38000866);
            check_val("stall_addr", bus.rom_addr, 6'h04);
            check_val("stall_cnt", bus.fetch_cnt, 3);
        end
        bus.id_stall = 0;
        tick();
        check_val("unstall_pc", bus.if_pc, 6'h04);

        // halt at pc 5, hold, halt+resume, resume
        bus.halt = 1;
        tick();
        check_val("halt_valid", bus.if_valid, 0);
        check_val("halt_flag", bus.halted, 1);
        bus.halt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("halt_addr", bus.rom_addr, 6'h05);
        end
        bus.halt = 1; bus.resume = 1;
        tick();
        check_val("halt_wins", bus.halted, 1);
        bus.halt = 0;
        tick();
        check_val("resumed", bus.halted, 0);
        bus.resume = 0;
        tick();
        check_val("resume_pc", bus.if_pc, 6'h05);

        // redirect, then redirect with stall
        for (int r = 0; r < 2; r++) begin
            bus.redirect = 1; bus.redirect_pc = 6'h0A; bus.id_stall = (r == 1);
            tick();
            check_val("redir_bubble", bus.if_valid, 0);
            bus.redirect = 0; bus.id_stall = 0;
            tick();
            check_val("redir_pc", bus.if_pc, 6'h0A);
            check_val("redir_inst", bus.if_inst, 32'h04100841);
        end

        // wrap
        bus.redirect = 1; bus.redirect_pc = 6'h3F;
        tick();
        bus.redirect = 0;
        tick();
        check_val("wrap_pc3f", bus.if_pc, 6'h3F);
        tick();
        check_val("wrap_pc00", bus.if_pc, 6'h00);
        check_val("wrap_addr", bus.rom_addr, 6'h01);

`ifdef IFETCH_STEP_EN
        rst = 1; bus.dbg_step_mode = 1;
        tick();
        rst = 0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            bus.dbg_step = 1;
            tick();
            check_val("step_pc", bus.if_pc, k);
            check_val("step_valid", bus.if_valid, 1);
            bus.dbg_step = 0;
            for (int j = 0; j < 3; j++) begin
                tick();
                check_val("step_gap", bus.if_valid, 0);
            end
        end
        check_val("step_cnt", bus.fetch_cnt, 3);
        bus.dbg_step_mode = 0;
`endif

        // random phase
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 99) == 0);
            bus.id_stall    = ($urandom_range(0, 99) < 20);
            bus.redirect    = ($urandom_range(0, 99) < 8);
            bus.redirect_pc = 6'($urandom);
            bus.halt        = ($urandom_range(0, 99) < 5);
            bus.resume      = ($urandom_range(0, 99) < 25);
`ifdef IFETCH_STEP_EN
            if ($urandom_range(0, 99) < 3) bus.dbg_step_mode = ~bus.dbg_step_mode;
            bus.dbg_step = ($urandom_range(0, 99) < 30);
`endif
            tick();
        end

        // saturation: long free run
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        chk_en = 0;
        repeat (65540) tick();
        chk_en = 1;
        check_val("sat_cnt", bus.fetch_cnt, 16'hFFFF);
        compare_all();
        tick();
        check_val("sat_hold", bus.fetch_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
